fft_stage_sequencer: RTL and testbench
======================================

# fft_stage_sequencer

Controller that feeds one radix-2 stage of the streaming FFT. It accepts a natural-order sample stream and stores the first half of each butterfly block in a local buffer. It then emits the stream as serial pairs (x[n], x[n+STRIDE]) in the two-sample order the `radix_2_butterfly` datapath consumes, together with the matching twiddle ROM address. It sits between the previous stage (or the input port) and the butterfly and owns all block, pair and frame counting for its stage.

## Interface
- `DATA_WIDTH`, 16, sample width (two's complement).
- `FFT_SIZE`, 16, points per frame; power of two, 2..4096.
- `STAGE`, 0, stage index, 0..log2(FFT_SIZE)-1.
- Derived: `STRIDE` = FFT_SIZE >> (STAGE+1).
- Derived: `TW_WIDTH` = max(1, log2(FFT_SIZE)-1).

Ports:
- `clkIn`  in  1  clock; all logic on the rising edge.
- `rstIn`  in  1  synchronous, active-high reset.
- `enIn`  in  1  global clock enable; low freezes all state and registered outputs.
- `validIn`  in  1  input sample valid.
- `dataIn`  in  DATA_WIDTH  input sample.
- `readyOut`  out  1  block can accept `dataIn` this cycle (combinational).
- `bfValidOut`  out  1  `bfDataOut` valid; drives butterfly `validIn`.
- `bfDataOut`  out  DATA_WIDTH  sample to butterfly; bit-exact copy, no arithmetic.
- `twAddrOut`  out  TW_WIDTH  twiddle address for the current pair.
- `pairFirstOut`  out  1  high with the first sample of each pair.
- `frameLastOut`  out  1  high with the final output sample of a frame.

## Operation
- An input transfer occurs when `enIn && validIn && readyOut`. `validIn` is ignored otherwise.
- `readyOut` = `enIn && !rstIn && state != PAIR_A`.
- Storage: a buffer of STRIDE words, indexed by the pair counter `cnt` (0..STRIDE-1). A block counter `blk` counts 0..FFT_SIZE/(2*STRIDE)-1.
- State machine (reset state FILL); all transitions are qualified by `enIn`:
  - FILL: each transfer writes `dataIn` to buf[cnt] and produces no output.
    - Transfer with cnt==STRIDE-1 -> PAIR_A, cnt=0.
    - Otherwise cnt++.
  - PAIR_A: unconditionally, with no input needed, emits buf[cnt] with `pairFirstOut`=1 and `twAddrOut` = cnt << STAGE, then -> PAIR_B.
  - PAIR_B: waits for a transfer, then emits `dataIn` with `pairFirstOut`=0.
    - If cnt==STRIDE-1: -> FILL, cnt=0, and blk increments, wrapping to 0 after the last block.
    - Otherwise: -> PAIR_A, cnt++.
- `frameLastOut` = 1 on the PAIR_B emission where cnt==STRIDE-1 and blk is the last block.
- `twAddrOut` holds its value through the PAIR_B sample.
- STRIDE==1 (last stage): FILL holds exactly one sample, and each block is one pair.
- Buffer read and write never target the same address in the same cycle. A FILL write at cnt=k completes before the PAIR_A read of k.

## Timing
- Latency: an emission decided in cycle t appears on `bfValidOut`/`bfDataOut` at cycle t+1 (registered outputs).
- Sustained rate: 2*STRIDE input samples per 3*STRIDE enabled cycles when `validIn` is held high.
- Butterfly outputs follow with its own 3-cycle latency; this block does not observe them.
- `bfValidOut` is a single-cycle pulse per emission. The two samples of a pair are always emitted in adjacent enabled cycles when the input does not stall in PAIR_B.
- `enIn` low: state, counters, buffer and all registered outputs hold; `readyOut`=0. Resuming continues exactly where frozen.
- Reset, including mid-frame: in the cycle after `rstIn` is sampled high:
  - state=FILL, cnt=0, blk=0;
  - `bfValidOut`=0, `bfDataOut`=0, `twAddrOut`=0, `pairFirstOut`=0, `frameLastOut`=0.
  - Buffer contents are don't-care. The partial frame is discarded; no partial pair is emitted.
- `readyOut`=0 while `rstIn` is high.

## Test plan
- N=8, STAGE=0, input 0..7 back-to-back with `enIn`=1 -> `bfDataOut` sequence 0,4,1,5,2,6,3,7. `twAddrOut` = 0,1,2,3 on each `pairFirstOut`. `frameLastOut` only with sample 7. `readyOut` low exactly in the 4 PAIR_A cycles.
- N=8, STAGE=1, input 0..7 -> outputs 0,2,1,3,4,6,5,7. `twAddrOut` = 0,2,0,2.
- N=8, STAGE=2, two frames 0..15 -> pairs (0,1),(2,3)…(14,15). `twAddrOut` always 0. `frameLastOut` on samples 7 and 15.
- Random `validIn` gaps and random `enIn` low cycles on the STAGE=0 frame -> same output sequence as the first scenario. Outputs frozen and no new `bfValidOut` pulse while `enIn`=0.
- Assert `rstIn` for 1 cycle after input 5 of an N=8 STAGE=0 frame, then send 0..7 -> all outputs 0 the cycle after reset. The next output sequence is exactly 0,4,1,5,2,6,3,7.
- Negative values (-32768, 32767, -1) through STAGE=0 -> `bfDataOut` bit-identical, with no sign change.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
// Input reorder/sequencer for one radix-2 FFT stage. It buffers the first half
// of each butterfly block and then emits (x[n], x[n+STRIDE]) pairs, each with its
// twiddle address, to the butterfly datapath.
module fft_stage_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FFT_SIZE   = 16,
  parameter int unsigned STAGE      = 0,
  localparam int unsigned LOG2N     = $clog2(FFT_SIZE),
  localparam int unsigned TW_WIDTH  = (LOG2N > 1) ? LOG2N - 1 : 1
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  enIn,
  input  logic                  validIn,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic                  readyOut,
  output logic                  bfValidOut,
  output logic [DATA_WIDTH-1:0] bfDataOut,
  output logic [TW_WIDTH-1:0]   twAddrOut,
  output logic                  pairFirstOut,
  output logic                  frameLastOut
);

  localparam int unsigned STRIDE = FFT_SIZE >> (STAGE + 1);
  localparam int unsigned CNT_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int unsigned NBLK   = 1 << STAGE;
  localparam int unsigned BLK_W  = (STAGE > 0) ? STAGE : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STRIDE - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(NBLK - 1);

  typedef enum logic [1:0] {StFill, StPairA, StPairB} state_e;

  state_e                  r_state, w_state_d;
  logic [CNT_W-1:0]        r_cnt, w_cnt_d;
  logic [BLK_W-1:0]        r_blk, w_blk_d;
  logic                    r_bf_valid, w_bf_valid_d;
  logic [DATA_WIDTH-1:0]   r_bf_data, w_bf_data_d;
  logic [TW_WIDTH-1:0]     r_tw_addr, w_tw_addr_d;
  logic                    r_pair_first, w_pair_first_d;
  logic                    r_frame_last, w_frame_last_d;
  logic [DATA_WIDTH-1:0]   r_buf [STRIDE];

  logic                    w_xfer;
  logic                    w_buf_we;
  logic [TW_WIDTH-1:0]     w_tw;

  assign readyOut = enIn && !rstIn && (r_state != StPairA);
  assign w_xfer   = enIn && validIn && readyOut;
  assign w_buf_we = w_xfer && (r_state == StFill);
  assign w_tw     = TW_WIDTH'(r_cnt) << STAGE;

  assign bfValidOut   = r_bf_valid;
  assign bfDataOut    = r_bf_data;
  assign twAddrOut    = r_tw_addr;
  assign pairFirstOut = r_pair_first;
  assign frameLastOut = r_frame_last;

  // First-half sample buffer; contents need no reset.
  always_ff @(posedge clkIn) begin
    if (w_buf_we) begin
      r_buf[r_cnt] <= dataIn;
    end
  end

  // State, counters and registered outputs; everything holds while enIn is low.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      r_state      <= StFill;
      r_cnt        <= '0;
      r_blk        <= '0;
      r_bf_valid   <= 1'b0;
      r_bf_data    <= '0;
      r_tw_addr    <= '0;
      r_pair_first <= 1'b0;
      r_frame_last <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_blk        <= w_blk_d;
      r_bf_valid   <= w_bf_valid_d;
      r_bf_data    <= w_bf_data_d;
      r_tw_addr    <= w_tw_addr_d;
      r_pair_first <= w_pair_first_d;
      r_frame_last <= w_frame_last_d;
    end
  end

  // Next-state and emission decode.
  always_comb begin
    w_state_d       = r_state;
    w_cnt_d         = r_cnt;
    w_blk_d         = r_blk;
    w_bf_valid_d    = r_bf_valid;
    w_bf_data_d     = r_bf_data;
    w_tw_addr_d     = r_tw_addr;
    w_pair_first_d  = r_pair_first;
    w_frame_last_d  = r_frame_last;
    if (enIn) begin
      // Pulse-type outputs drop on any enabled cycle without an emission.
      w_bf_valid_d   = 1'b0;
      w_pair_first_d = 1'b0;
      w_frame_last_d = 1'b0;
      unique case (r_state)
        StFill: begin
          if (w_xfer) begin
            if (r_cnt == CNT_LAST) begin
              w_state_d = StPairA;
              w_cnt_d   = '0;
            end else begin
              w_cnt_d = r_cnt + 1'b1;
            end
          end
        end
        StPairA: begin
          w_bf_valid_d   = 1'b1;
          w_bf_data_d    = r_buf[r_cnt];
          w_pair_first_d = 1'b1;
          w_tw_addr_d    = w_tw;
          w_state_d      = StPairB;
        end
        StPairB: begin
          if (w_xfer) begin
            w_bf_valid_d = 1'b1;
            w_bf_data_d  = dataIn;
            if (r_cnt == CNT_LAST) begin
              w_state_d      = StFill;
              w_cnt_d        = '0;
              w_frame_last_d = (r_blk == BLK_LAST);
              w_blk_d        = (r_blk == BLK_LAST) ? '0 : r_blk + 1'b1;
            end else begin
              w_state_d = StPairA;
              w_cnt_d   = r_cnt + 1'b1;
            end
          end
        end
        default: begin
          w_state_d = StFill;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench: three 8-point sequencers (stages 0, 1, 2) driven one at a time.
module tb_fft_stage_sequencer;

  localparam int DW = 16;
  localparam int N  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            en  [3];
  logic            vld [3];
  logic [DW-1:0]   din [3];
  logic            rdy [3];
  logic            bv  [3];
  logic [DW-1:0]   bd  [3];
  logic [1:0]      tw  [3];
  logic            pf  [3];
  logic            fl  [3];

  int              n_cmp = 0;
  int              n_bad = 0;
  logic [DW-1:0]   stim  [$];
  logic [DW-1:0]   exp_d [$];
  int              exp_tw [$];
  int              exp_fl [$];
  int              rdy_low;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fft_stage_sequencer #(
      .DATA_WIDTH(DW),
      .FFT_SIZE  (N),
      .STAGE     (g)
    ) u_dut (
      .clkIn       (clk),
      .rstIn       (rst),
      .enIn        (en[g]),
      .validIn     (vld[g]),
      .dataIn      (din[g]),
      .readyOut    (rdy[g]),
      .bfValidOut  (bv[g]),
      .bfDataOut   (bd[g]),
      .twAddrOut   (tw[g]),
      .pairFirstOut(pf[g]),
      .frameLastOut(fl[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  task automatic chk_zero(input int s);
    chk("rst_bv", 32'(bv[s]), 0);
    chk("rst_bd", 32'(bd[s]), 0);
    chk("rst_tw", 32'(tw[s]), 0);
    chk("rst_pf", 32'(pf[s]), 0);
    chk("rst_fl", 32'(fl[s]), 0);
  endtask

  // Feed stim[0..n_in-1] into stage s and compare every emission with exp_*.
  task automatic run_stream(input int s, input int n_in, input bit rnd);
    int          idx = 0;
    int          got = 0;
    int          cyc = 0;
    bit          last_en = 1'b0;
    logic [DW-1:0] ob [$];
    logic [1:0]  otw [$];
    logic        opf [$];
    logic        ofl [$];
    rdy_low = 0;
    while (got < exp_d.size() && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (last_en && bv[s]) begin
        ob.push_back(bd[s]);
        otw.push_back(tw[s]);
        opf.push_back(pf[s]);
        ofl.push_back(fl[s]);
        got++;
      end else if (!last_en && got > 0) begin
        chk("frozen_bd", 32'(bd[s]), 32'(exp_d[got-1]));
      end
      if (got >= exp_d.size()) break;
      en[s]  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      vld[s] = (idx < n_in) && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      din[s] = (idx < n_in) ? stim[idx] : '0;
      #1;
      if (!en[s]) chk("rdy_en_low", 32'(rdy[s]), 0);
      else if (!rdy[s]) rdy_low++;
      if (en[s] && vld[s] && rdy[s]) idx++;
      last_en = en[s];
    end
    en[s]  = 1'b0;
    vld[s] = 1'b0;
    chk("out_count", got, exp_d.size());
    for (int i = 0; i < got; i++) begin
      chk("bf_data", 32'(ob[i]), 32'(exp_d[i]));
      chk("pair_first", 32'(opf[i]), 32'(i % 2 == 0));
      chk("tw_addr", 32'(otw[i]), exp_tw[i/2]);
      chk("frame_last", 32'(ofl[i]), exp_fl[i]);
    end
  endtask

  task automatic set_stage0_ramp();
    stim   = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    exp_d  = '{16'd0, 16'd4, 16'd1, 16'd5, 16'd2, 16'd6, 16'd3, 16'd7};
    exp_tw = '{0, 1, 2, 3};
    exp_fl = '{0, 0, 0, 0, 0, 0, 0, 1};
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      en[s] = 1'b0; vld[s] = 1'b0; din[s] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk_zero(s);
      chk("rdy_in_rst", 32'(rdy[s]), 0);
    end
    rst = 1'b0;

    // Stage 0 back-to-back
    set_stage0_ramp();
    run_stream(0, 8, 1'b0);
    chk("rdy_low_pair_a", rdy_low, 4);

    // Stage 1
    stim   = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    exp_d  = '{16'd0, 16'd2, 16'd1, 16'd3, 16'd4, 16'd6, 16'd5, 16'd7};
    exp_tw = '{0, 2, 0, 2};
    exp_fl = '{0, 0, 0, 0, 0, 0, 0, 1};
    run_stream(1, 8, 1'b0);

    // Stage 2, two frames: pairs are adjacent samples
    stim = {}; exp_d = {}; exp_tw = {}; exp_fl = {};
    for (int i = 0; i < 16; i++) begin
      stim.push_back(16'(i));
      exp_d.push_back(16'(i));
      exp_fl.push_back((i == 7 || i == 15) ? 1 : 0);
    end
    for (int p = 0; p < 8; p++) exp_tw.push_back(0);
    run_stream(2, 16, 1'b0);

    // Stage 0 with random valid gaps and enable drops
    set_stage0_ramp();
    run_stream(0, 8, 1'b1);

    // Mid-frame reset after input 5, then a clean frame
    set_stage0_ramp();
    exp_d  = '{16'd0, 16'd4, 16'd1, 16'd5};
    exp_tw = '{0, 1};
    exp_fl = '{0, 0, 0, 0};
    run_stream(0, 6, 1'b0);
    en[0] = 1'b1;
    rst   = 1'b1;
    #1;
    chk("rdy_rst_high", 32'(rdy[0]), 0);
    @(negedge clk);
    chk_zero(0);
    rst = 1'b0;
    en[0] = 1'b0;
    set_stage0_ramp();
    run_stream(0, 8, 1'b0);

    // Extreme signed values pass through bit-exact
    stim   = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001,
               16'h0005, 16'hFFFE, 16'h0000, 16'h0064};
    exp_d  = '{16'h8000, 16'h0005, 16'h7FFF, 16'hFFFE,
               16'hFFFF, 16'h0000, 16'h0001, 16'h0064};
    exp_tw = '{0, 1, 2, 3};
    exp_fl = '{0, 0, 0, 0, 0, 0, 0, 1};
    run_stream(0, 8, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
